// File: rtl/alu16_result_fifo_if.sv
// Handshake bundle between an ALU front end, the result FIFO, and its consumer.
// The slave modport is the FIFO's view; the master modport is the producer/consumer side.
interface alu16_result_fifo_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic        carry_out;
    logic        nBo;
    logic        nGo;
    logic [3:0]  opcode;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  out_tag;

    modport slave (
        input  in_valid, result, carry_out, nBo, nGo, opcode, mode, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_tag
    );

    modport master (
        output in_valid, result, carry_out, nBo, nGo, opcode, mode, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_tag
    );
endinterface

// File: rtl/alu16_result_fifo.sv
// Buffers ALU results with derived flags and the issuing {mode, opcode} tag.
// Strict FIFO, no pass-through when full, saturating count of refused pushes.
module alu16_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu16_result_fifo_if.slave  bus,
    output logic [4:0]          level,
    output logic [7:0]          drop_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [15:0] result;
        logic [4:0]  flags;   // {carry, zero, neg, nBo, nGo}
        logic [4:0]  tag;     // {mode, opcode}
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    assign bus.in_ready  = (level != 5'(DEPTH));
    assign bus.out_valid = (level != 5'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        wr_entry.result = bus.result;
        wr_entry.flags  = {bus.carry_out, (bus.result == 16'h0000), bus.result[15], bus.nBo, bus.nGo};
        wr_entry.tag    = {bus.mode, bus.opcode};
    end

    // Storage is deliberately left out of reset; only pointers define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: ;
            endcase
            if (bus.in_valid && !bus.in_ready && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.out_result = bus.out_valid ? head.result : 16'h0000;
    assign bus.out_flags  = bus.out_valid ? head.flags  : 5'h00;
    assign bus.out_tag    = bus.out_valid ? head.tag    : 5'h00;
endmodule

// File: doc/alu16_result_fifo.md
ALU16_RESULT_FIFO -- requirements
Module: alu16_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, entry count of the result buffer; legal values are powers of two, 2 to 16.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port in_valid  input  1  ALU outputs and issued command fields are valid this cycle.
REQ-005 Port in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 Port result  input  16  ALU result word.
REQ-007 Port carry_out  input  1  ALU carry out.
REQ-008 Port nBo  input  1  ALU active-low carry-propagate output.
REQ-009 Port nGo  input  1  ALU active-low carry-generate output.
REQ-010 Port opcode  input  4  opcode issued to the ALU for this result.
REQ-011 Port mode  input  1  mode issued to the ALU for this result.
REQ-012 Port out_valid  output  1  head entry is presented.
REQ-013 Port out_ready  input  1  consumer accepts the head entry this cycle.
REQ-014 Port out_result  output  16  head entry result.
REQ-015 Port out_flags  output  5  head entry {carry, zero, neg, nBo, nGo}.
REQ-016 Port out_tag  output  5  head entry {mode, opcode}.
REQ-017 Port level  output  5  number of stored entries, 0..DEPTH.
REQ-018 Port drop_count  output  8  count of offered entries refused while full, saturating.

Function
REQ-019 Push occurs on a clock edge when in_valid=1 and in_ready=1; pop occurs on a clock edge when out_valid=1 and out_ready=1.
REQ-020 in_ready shall equal (level != DEPTH); it does not depend on out_ready (no same-cycle pass-through when full).
REQ-021 out_valid shall equal (level != 0); out_valid shall not depend combinationally on in_valid.
REQ-022 Pushed entry: result, carry=carry_out, zero=(result==16'h0000), neg=result[15], nBo, nGo, tag={mode,opcode}, all sampled at the push edge.
REQ-023 Latency: an entry pushed into an empty buffer at edge N is presented with out_valid=1 in the cycle following edge N.
REQ-024 out_result/out_flags/out_tag shall present the oldest stored entry (strict FIFO order) and remain stable while out_valid=1 and out_ready=0.
REQ-025 When level=0, out_result, out_flags and out_tag shall be driven all zeros.
REQ-026 Simultaneous push and pop with 0<level<DEPTH: level unchanged, head advances, new entry appended at tail.
REQ-027 Push and pop at level=DEPTH: push is refused (in_ready=0), pop proceeds, level becomes DEPTH-1.
REQ-028 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-029 in_valid=1 with in_ready=0 at an edge shall increment drop_count by 1, saturating at 255; the entry is discarded.
REQ-030 out_ready while out_valid=0 has no effect; level never underflows or exceeds DEPTH.

Reset
REQ-031 rst_n=0 sampled at an edge shall clear pointers, level=0, drop_count=0, giving out_valid=0, in_ready=1, out_* all zeros in the following cycle.
REQ-032 Reset asserted mid-operation discards all stored entries; a push or pop coinciding with reset is ignored.
REQ-033 Storage array contents need not be reset; only pointers and counters are.

Verification
REQ-034 Single push result=16'h0000, carry_out=1, opcode=4'h9, mode=0, out_ready=0 -> next cycle out_valid=1, out_result=0, out_flags=5'b11000 (nBo/nGo as driven), out_tag=5'h09, level=1.
REQ-035 Push 4 entries results 1,2,3,4 with out_ready=0 -> level=4, in_ready=0; fifth push -> drop_count=1, level stays 4; then out_ready=1 four cycles -> out_result sequence 1,2,3,4, then out_valid=0, out_result=0.
REQ-036 Continuous push and pop for 10 cycles from level=2, results 16'h8000+i -> level stays 2, order preserved across pointer wrap, neg flag=1 on every entry.
REQ-037 Hold buffer full and drive in_valid=1 for 300 cycles -> drop_count saturates at 255 and does not wrap.
REQ-038 Fill to level=3, assert rst_n=0 for one edge together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, in_ready=1, drop_count=0.
REQ-039 Random push/pop traffic with a scoreboard model for 10k cycles -> zero ordering, flag or level mismatches.
